// File: rtl/fp_muldiv_iter_if.sv
// Operand/result handshake bundle for fp_muldiv_iter.
// The master side drives operands and out_ready; the slave side is the unit.
interface fp_muldiv_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         underflow;
    logic         div_by_zero;
    logic         invalid;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result,
        input  overflow, underflow, div_by_zero, invalid
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result,
        output overflow, underflow, div_by_zero, invalid
    );
endinterface

// File: rtl/fp_muldiv_iter.sv
// Iterative IEEE-754 multiply (shift-add) / divide (restoring), flush-to-zero.
// Truncating rounding by default; FPMD_RNE_EN selects round-to-nearest-even.
module fp_muldiv_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_muldiv_iter_if.slave io
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int M   = MAN_W + 1;
    localparam int Q   = MAN_W + 3;
    localparam int EW2 = EXP_W + 2;
    localparam int CW  = $clog2(MAN_W + 4);

    localparam logic [EXP_W-1:0]      EMAX = '1;
    localparam logic signed [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EINF = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] ONE  = EW2'(1);
    localparam logic signed [EW2-1:0] ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ITER, S_NORM, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  op_q, op_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d;
    logic                  sign_q, sign_d;
    logic signed [EW2-1:0] exp_q, exp_d;
    logic [2*M-1:0]        acc_q, acc_d;
    logic [2*M-1:0]        sh_q, sh_d;
    logic [M-1:0]          mb_q, mb_d;
    logic [W-1:0]          result_q, result_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  dbz_q, dbz_d, inv_q, inv_d;

    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;
    logic                  a_zero, a_inf, a_nan;
    logic                  b_zero, b_inf, b_nan;
    logic                  sgn;
    logic signed [EW2-1:0] ea_s, eb_s;
    logic                  sp_hit, sp_inv, sp_dbz;
    logic [W-1:0]          sp_res, inf_res, zero_res, qnan_res;

    assign ea   = a_q[W-2:MAN_W];
    assign eb   = b_q[W-2:MAN_W];
    assign fa   = a_q[MAN_W-1:0];
    assign fb   = b_q[MAN_W-1:0];
    assign sgn  = a_q[W-1] ^ b_q[W-1];
    assign ea_s = $signed({2'b00, ea});
    assign eb_s = $signed({2'b00, eb});

    // Subnormals collapse into zero here: any zero exponent is a zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EMAX) && (fa == '0);
    assign b_inf  = (eb == EMAX) && (fb == '0);
    assign a_nan  = (ea == EMAX) && (fa != '0);
    assign b_nan  = (eb == EMAX) && (fb != '0);

    assign inf_res  = {sgn, EMAX, {MAN_W{1'b0}}};
    assign zero_res = {sgn, {(W-1){1'b0}}};
    assign qnan_res = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    always_comb begin
        sp_hit = 1'b0;
        sp_inv = 1'b0;
        sp_dbz = 1'b0;
        sp_res = zero_res;
        if (a_nan || b_nan) begin
            sp_hit = 1'b1;
            sp_res = qnan_res;
        end else if (!op_q) begin
            if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                sp_hit = 1'b1;
                sp_inv = 1'b1;
                sp_res = qnan_res;
            end else if (a_inf || b_inf) begin
                sp_hit = 1'b1;
                sp_res = inf_res;
            end else if (a_zero || b_zero) begin
                sp_hit = 1'b1;
            end
        end else begin
            if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                sp_hit = 1'b1;
                sp_inv = 1'b1;
                sp_res = qnan_res;
            end else if (a_inf) begin
                sp_hit = 1'b1;
                sp_res = inf_res;
            end else if (b_zero) begin
                sp_hit = 1'b1;
                sp_dbz = 1'b1;
                sp_res = inf_res;
            end else if (b_inf || a_zero) begin
                sp_hit = 1'b1;
            end
        end
    end

    logic [M:0]   rem;
    logic         rem_ge;
    logic [M-1:0] rem_n;
    logic [CW-1:0] cnt_last;

    assign rem      = sh_q[M:0];
    assign rem_ge   = rem >= {1'b0, mb_q};
    assign rem_n    = rem_ge ? M'(rem - {1'b0, mb_q}) : rem[M-1:0];
    assign cnt_last = op_q ? CW'(MAN_W + 2) : CW'(MAN_W);

    logic                  n_top;
    logic [MAN_W-1:0]      n_mant, n_mant_r;
    logic signed [EW2-1:0] n_exp;
    logic [W-1:0]          n_res;
    logic                  n_ovf, n_unf;
`ifdef FPMD_RNE_EN
    logic                  n_guard, n_sticky, n_inc, n_cy;
`endif

    always_comb begin
        n_top  = op_q ? acc_q[Q-1] : acc_q[2*M-1];
        n_mant = op_q ?
                 (n_top ? acc_q[MAN_W+1:2] : acc_q[MAN_W:1]) :
                 (n_top ? acc_q[2*MAN_W:MAN_W+1] : acc_q[2*MAN_W-1:MAN_W]);
        n_exp  = exp_q;
        if (!op_q && n_top) n_exp = exp_q + ONE;
        if (op_q && !n_top) n_exp = exp_q - ONE;
`ifdef FPMD_RNE_EN
        if (op_q) begin
            n_guard  = n_top ? acc_q[1] : acc_q[0];
            n_sticky = (n_top && acc_q[0]) || (sh_q != '0);
        end else begin
            n_guard  = n_top ? acc_q[MAN_W] : acc_q[MAN_W-1];
            n_sticky = n_top ? (acc_q[MAN_W-1:0] != '0)
                             : (acc_q[MAN_W-2:0] != '0);
        end
        n_inc = n_guard && (n_sticky || n_mant[0]);
        {n_cy, n_mant_r} = {1'b0, n_mant} + (MAN_W+1)'(n_inc);
        // All-ones mantissa rolled over: value is 2.0, i.e. 1.0 one binade up.
        if (n_cy) n_exp = n_exp + ONE;
`else
        n_mant_r = n_mant;
`endif
        n_ovf = 1'b0;
        n_unf = 1'b0;
        n_res = {sign_q, n_exp[EXP_W-1:0], n_mant_r};
        if (n_exp >= EINF) begin
            n_ovf = 1'b1;
            n_res = {sign_q, EMAX, {MAN_W{1'b0}}};
        end else if (n_exp <= ZERO) begin
            n_unf = 1'b1;
            n_res = {sign_q, {(W-1){1'b0}}};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        mb_d     = mb_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dbz_d    = dbz_q;
        inv_d    = inv_q;
        unique case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    op_d    = io.op;
                    a_d     = io.a;
                    b_d     = io.b;
                    cnt_d   = '0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d = sgn;
                exp_d  = op_q ? (ea_s - eb_s + BIAS) : (ea_s + eb_s - BIAS);
                // Early-out results spend a second cycle here for a fixed latency of 2.
                if (sp_hit) begin
                    if (cnt_q == '0) begin
                        cnt_d = CW'(1);
                    end else begin
                        cnt_d    = '0;
                        state_d  = S_DONE;
                        result_d = sp_res;
                        ovf_d    = 1'b0;
                        unf_d    = 1'b0;
                        dbz_d    = sp_dbz;
                        inv_d    = sp_inv;
                    end
                end else begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    sh_d    = {{M{1'b0}}, 1'b1, fa};
                    mb_d    = {1'b1, fb};
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (op_q) begin
                    acc_d = {acc_q[2*M-2:0], rem_ge};
                    sh_d  = {{(M-1){1'b0}}, rem_n, 1'b0};
                end else begin
                    if (mb_q[0]) acc_d = acc_q + sh_q;
                    sh_d = sh_q << 1;
                    mb_d = mb_q >> 1;
                end
                if (cnt_q == cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_NORM: begin
                result_d = n_res;
                ovf_d    = n_ovf;
                unf_d    = n_unf;
                dbz_d    = 1'b0;
                inv_d    = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (io.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            mb_q     <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            mb_q     <= mb_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dbz_q    <= dbz_d;
            inv_q    <= inv_d;
        end
    end

    assign io.in_ready    = (state_q == S_IDLE);
    assign io.out_valid   = (state_q == S_DONE);
    assign io.result      = result_q;
    assign io.overflow    = ovf_q;
    assign io.underflow   = unf_q;
    assign io.div_by_zero = dbz_q;
    assign io.invalid     = inv_q;
endmodule

// File: tb/tb_fp_muldiv_iter.sv
// Bench for fp_muldiv_iter: directed corner cases plus random operands
// against an integer-arithmetic reference model (single and double).
module tb_fp_muldiv_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_muldiv_iter_if #(.EXP_W(8),  .MAN_W(23)) sp_if ();
    fp_muldiv_iter_if #(.EXP_W(11), .MAN_W(52)) dp_if ();

    fp_muldiv_iter #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (sp_if)
    );

    fp_muldiv_iter #(.EXP_W(11), .MAN_W(52)) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (dp_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flags are packed {overflow, underflow, div_by_zero, invalid}.
    task automatic ref_model(input int ew, input int mw, input logic op,
                             input logic [63:0] a, input logic [63:0] b,
                             output logic [63:0] res, output logic [3:0] flg,
                             output int lat);
        logic [63:0]  emax, fmask, ea, eb, fa, fb, mant;
        logic [63:0]  inf_r, zero_r, qnan;
        logic [127:0] ma, mb, p, q, r;
        logic         s, g, st, done;
        bit           az, ai, an, bz, bi, bn;
        int           e, sh, bias;
        emax  = (64'd1 << ew) - 1;
        fmask = (64'd1 << mw) - 1;
        ea = (a >> mw) & emax;
        eb = (b >> mw) & emax;
        fa = a & fmask;
        fb = b & fmask;
        s  = a[ew+mw] ^ b[ew+mw];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == emax) && (fa == 0);
        bi = (eb == emax) && (fb == 0);
        an = (ea == emax) && (fa != 0);
        bn = (eb == emax) && (fb != 0);
        zero_r = {63'd0, s} << (ew + mw);
        inf_r  = zero_r | (emax << mw);
        qnan   = (emax << mw) | (64'd1 << (mw - 1));
        flg  = 4'b0000;
        lat  = 2;
        res  = zero_r;
        done = 1'b1;
        if (an || bn) res = qnan;
        else if (!op && ((az && bi) || (ai && bz))) begin
            res = qnan; flg = 4'b0001;
        end else if (!op && (ai || bi)) res = inf_r;
        else if (!op && (az || bz)) res = zero_r;
        else if (op && ((az && bz) || (ai && bi))) begin
            res = qnan; flg = 4'b0001;
        end else if (op && ai) res = inf_r;
        else if (op && bz) begin
            res = inf_r; flg = 4'b0010;
        end else if (op && (bi || az)) res = zero_r;
        else done = 1'b0;
        if (!done) begin
            lat  = op ? mw + 5 : mw + 3;
            bias = (1 << (ew - 1)) - 1;
            ma = {64'd0, fa | (64'd1 << mw)};
            mb = {64'd0, fb | (64'd1 << mw)};
            if (!op) begin
                p = ma * mb;
                e = int'(ea) + int'(eb) - bias;
                if (p >= (128'd1 << (2 * mw + 1))) begin
                    e++; sh = mw + 1;
                end else sh = mw;
                mant = 64'(p >> sh) & fmask;
                g    = p[sh-1];
                st   = (p & ((128'd1 << (sh - 1)) - 1)) != 0;
            end else begin
                q = (ma << (mw + 2)) / mb;
                r = (ma << (mw + 2)) % mb;
                e = int'(ea) - int'(eb) + bias;
                if (q >= (128'd1 << (mw + 2))) sh = 2;
                else begin
                    sh = 1; e--;
                end
                mant = 64'(q >> sh) & fmask;
                g    = q[sh-1];
                st   = (sh == 2 && q[0]) || (r != 0);
            end
`ifdef FPMD_RNE_EN
            if (g && (st || mant[0])) begin
                mant++;
                if (mant > fmask) begin
                    mant = 0; e++;
                end
            end
`endif
            if (e >= int'(emax)) begin
                res = inf_r; flg = 4'b1000;
            end else if (e <= 0) begin
                res = zero_r; flg = 4'b0100;
            end else begin
                res = zero_r | (64'(e) << mw) | mant;
            end
        end
    endtask

    task automatic run_sp(input logic op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output logic [3:0] flg, output int lat);
        @(negedge clk);
        sp_if.op = op; sp_if.a = a; sp_if.b = b;
        sp_if.in_valid = 1'b1;
        @(posedge clk);
        #1 sp_if.in_valid = 1'b0;
        lat = 0;
        while (!sp_if.out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        res = sp_if.result;
        flg = {sp_if.overflow, sp_if.underflow,
               sp_if.div_by_zero, sp_if.invalid};
    endtask

    task automatic ack_sp();
        @(negedge clk);
        sp_if.out_ready = 1'b1;
        @(posedge clk);
        #1 sp_if.out_ready = 1'b0;
    endtask

    task automatic run_dp(input logic op, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res,
                          output logic [3:0] flg, output int lat);
        @(negedge clk);
        dp_if.op = op; dp_if.a = a; dp_if.b = b;
        dp_if.in_valid = 1'b1;
        @(posedge clk);
        #1 dp_if.in_valid = 1'b0;
        lat = 0;
        while (!dp_if.out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        res = dp_if.result;
        flg = {dp_if.overflow, dp_if.underflow,
               dp_if.div_by_zero, dp_if.invalid};
        @(negedge clk);
        dp_if.out_ready = 1'b1;
        @(posedge clk);
        #1 dp_if.out_ready = 1'b0;
    endtask

    task automatic model_sp(input string tag, input logic op,
                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        logic [63:0] eres;
        logic [3:0]  flg, eflg;
        int          lat, elat;
        run_sp(op, a, b, res, flg, lat);
        ref_model(8, 23, op, {32'd0, a}, {32'd0, b}, eres, eflg, elat);
        chk({tag, " res"}, {32'd0, res}, eres);
        chk({tag, " flags"}, {60'd0, flg}, {60'd0, eflg});
        chk({tag, " lat"}, 64'(lat), 64'(elat));
        ack_sp();
    endtask

    function automatic logic [31:0] rnd_sp();
        logic [7:0]  e;
        logic [22:0] f;
        int          sel;
        sel = $urandom_range(0, 15);
        f   = 23'($urandom);
        case (sel)
            0: begin
                e = 8'd0;
                if ($urandom_range(0, 1) == 1) f = '0;
            end
            1: begin
                e = 8'hFF;
                if ($urandom_range(0, 2) != 0) f = '0;
            end
            2: e = 8'($urandom_range(1, 254));
            3: e = 8'($urandom_range(1, 40));
            4: e = 8'($urandom_range(215, 254));
            5: begin
                e = 8'($urandom_range(100, 154));
                f = '1;
            end
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, f};
    endfunction

    logic [31:0] r32;
    logic [63:0] r64, e64;
    logic [3:0]  f4, ef4;
    int          lt, elt;

    initial begin
        sp_if.in_valid = 1'b0; sp_if.op = 1'b0;
        sp_if.a = '0; sp_if.b = '0; sp_if.out_ready = 1'b0;
        dp_if.in_valid = 1'b0; dp_if.op = 1'b0;
        dp_if.a = '0; dp_if.b = '0; dp_if.out_ready = 1'b0;

        #12;
        chk("rst out_valid", {63'd0, sp_if.out_valid}, 64'd0);
        chk("rst result", {32'd0, sp_if.result}, 64'd0);
        chk("rst flags", {60'd0, sp_if.overflow, sp_if.underflow,
            sp_if.div_by_zero, sp_if.invalid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst in_ready", {63'd0, sp_if.in_ready}, 64'd1);

        run_sp(1'b0, 32'h3F800000, 32'h40000000, r32, f4, lt);
        chk("mul 1x2 res", {32'd0, r32}, 64'h40000000);
        chk("mul 1x2 lat", 64'(lt), 64'd26);
        chk("mul 1x2 flags", {60'd0, f4}, 64'd0);
        ack_sp();

        run_sp(1'b1, 32'h3F800000, 32'h40000000, r32, f4, lt);
        chk("div 1/2 res", {32'd0, r32}, 64'h3F000000);
        chk("div 1/2 lat", 64'(lt), 64'd28);
        ack_sp();

        run_sp(1'b1, 32'h3F800000, 32'h40400000, r32, f4, lt);
`ifdef FPMD_RNE_EN
        chk("div 1/3 res", {32'd0, r32}, 64'h3EAAAAAB);
`else
        chk("div 1/3 res", {32'd0, r32}, 64'h3EAAAAAA);
`endif
        ack_sp();

        run_sp(1'b0, 32'h7EB48E52, 32'h41200000, r32, f4, lt);
        chk("ovf res", {32'd0, r32}, 64'h7F800000);
        chk("ovf flags", {60'd0, f4}, 64'b1000);
        ack_sp();

        run_sp(1'b0, 32'h0DA24260, 32'h0DA24260, r32, f4, lt);
        chk("unf res", {32'd0, r32}, 64'h00000000);
        chk("unf flags", {60'd0, f4}, 64'b0100);
        ack_sp();

        run_sp(1'b1, 32'h3F800000, 32'h00000000, r32, f4, lt);
        chk("dbz res", {32'd0, r32}, 64'h7F800000);
        chk("dbz flags", {60'd0, f4}, 64'b0010);
        chk("dbz lat", 64'(lt), 64'd2);
        ack_sp();

        run_sp(1'b0, 32'h00000000, 32'h7F800000, r32, f4, lt);
        chk("0xinf res", {32'd0, r32}, 64'h7FC00000);
        chk("0xinf flags", {60'd0, f4}, 64'b0001);
        ack_sp();

        run_sp(1'b0, 32'h3FC00000, 32'h40400000, r32, f4, lt);
        chk("hold first", {32'd0, r32}, 64'h40900000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sp_if.in_valid = 1'b1;
            sp_if.a = 32'h41200000;
            sp_if.b = 32'h41200000;
            @(posedge clk);
            #1;
            chk("hold res", {32'd0, sp_if.result}, 64'h40900000);
            chk("hold in_ready", {63'd0, sp_if.in_ready}, 64'd0);
            chk("hold out_valid", {63'd0, sp_if.out_valid}, 64'd1);
            chk("hold flags", {60'd0, sp_if.overflow, sp_if.underflow,
                sp_if.div_by_zero, sp_if.invalid}, 64'd0);
        end
        @(negedge clk);
        sp_if.in_valid = 1'b0;
        ack_sp();
        chk("post ack in_ready", {63'd0, sp_if.in_ready}, 64'd1);
        chk("post ack out_valid", {63'd0, sp_if.out_valid}, 64'd0);
        chk("post ack keep", {32'd0, sp_if.result}, 64'h40900000);

        @(negedge clk);
        sp_if.op = 1'b0;
        sp_if.a = 32'h40000000;
        sp_if.b = 32'h40400000;
        sp_if.in_valid = 1'b1;
        @(posedge clk);
        #1 sp_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", {63'd0, sp_if.out_valid}, 64'd0);
        chk("midrst result", {32'd0, sp_if.result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1 chk("midrst no output", {63'd0, sp_if.out_valid}, 64'd0);
        model_sp("after rst", 1'b1, 32'h40E00000, 32'h40400000);

        for (int i = 0; i < 150; i++) begin
            model_sp("rand", 1'($urandom), rnd_sp(), rnd_sp());
        end

        r64 = $realtobits(2121121.123123);
        run_dp(1'b0, r64, $realtobits(1212121.121212), e64, f4, lt);
        ref_model(11, 52, 1'b0, r64, $realtobits(1212121.121212),
                  r64, ef4, elt);
        chk("dp mul res", e64, r64);
        chk("dp mul flags", {60'd0, f4}, {60'd0, ef4});
        chk("dp mul lat", 64'(lt), 64'd55);

        for (int i = 0; i < 10; i++) begin
            logic [63:0] da, db;
            logic        dop;
            da  = {1'($urandom), 11'($urandom_range(900, 1150)),
                   20'($urandom), 32'($urandom)};
            db  = {1'($urandom), 11'($urandom_range(900, 1150)),
                   20'($urandom), 32'($urandom)};
            dop = 1'($urandom);
            run_dp(dop, da, db, r64, f4, lt);
            ref_model(11, 52, dop, da, db, e64, ef4, elt);
            chk("dp rand res", r64, e64);
            chk("dp rand lat", 64'(lt), 64'(elt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_muldiv_iter.md
FP_MULDIV_ITER -- requirements
Module: fp_muldiv_iter

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent width (11 for double precision).
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored fraction width (52 for double precision); W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports in_valid  input  1 and in_ready  output  1  operand handshake.
REQ-006 SHALL have port op  input  1  operation: 0 = multiply, 1 = divide (a/b).
REQ-007 SHALL have ports a, b  input  W  IEEE-754-format operands.
REQ-008 SHALL have ports out_valid  output  1 and out_ready  input  1  result handshake.
REQ-009 SHALL have port result  output  W  packed IEEE-754 result.
REQ-010 SHALL have ports overflow, underflow, div_by_zero, invalid  output  1 each  exception flags qualified by out_valid.

Function
REQ-011 SHALL implement FSM IDLE -> UNPACK -> ITER -> NORM -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-012 SHALL capture op/a/b on the edge where in_valid && in_ready; IDLE -> UNPACK.
REQ-013 UNPACK SHALL decode sign, exponent and hidden bit; subnormal inputs treated as signed zero (flush-to-zero).
REQ-014 UNPACK SHALL route special cases directly to DONE: NaN operand -> 0x7FC00000-style canonical qNaN (sign 0, fraction MSB 1), invalid 0; 0*Inf, 0/0, Inf/Inf -> qNaN, invalid 1; finite nonzero/0 -> Inf with sign a^b, div_by_zero 1; other Inf or zero results -> signed Inf/zero, no flag.
REQ-015 ITER SHALL run a counter: multiply = shift-add over MAN_W+1 cycles; divide = restoring division over MAN_W+3 cycles, producing quotient plus guard bits and a sticky remainder bit.
REQ-016 NORM SHALL normalise (at most one-bit shift), compute biased exponent (ea+eb-bias or ea-eb+bias) at EXP_W+2 signed width, round, and pack in one cycle.
REQ-017 SHALL use round-toward-zero (truncate) unless FPMD_RNE_EN is defined.
REQ-018 Exponent >= 2^EXP_W-1 after rounding SHALL give signed Inf and overflow = 1.
REQ-019 Exponent <= 0 SHALL give signed zero and underflow = 1 (no subnormal outputs).
REQ-020 Latency from accept edge to out_valid: MAN_W+3 cycles multiply, MAN_W+5 divide, 2 for specials (26 / 28 / 2 at defaults).
REQ-021 DONE SHALL hold out_valid, result and flags stable until out_ready; on out_valid && out_ready -> IDLE, in_ready high next cycle.
REQ-022 No new operand SHALL be accepted while busy; in_valid outside IDLE is ignored.
REQ-023 result and flags SHALL retain their last values after handshake until the next result is loaded.

Reset
REQ-024 rst_n low SHALL force IDLE, counter 0, in_ready 1 (after release), out_valid 0, result 0, all flags 0, regardless of operation in progress.
REQ-025 An operation interrupted by reset SHALL be discarded; no output produced for it.

Configuration
REQ-026 Macro FPMD_RNE_EN defined: round-to-nearest-even from guard+sticky; mantissa carry renormalises and may raise overflow.
REQ-027 Macro FPMD_RNE_EN undefined: truncation; rounding logic absent; latency unchanged.

Verification
REQ-028 Defaults: a=0x3F800000, b=0x40000000, op=0 -> result 0x40000000, out_valid 26 cycles after accept, flags 0; op=1 -> 0x3F000000 after 28.
REQ-029 a=1.0, b=3.0, op=1 -> 0x3EAAAAAA without FPMD_RNE_EN, 0x3EAAAAAB with it.
REQ-030 a=1.2e38, b=10.0, op=0 -> 0x7F800000, overflow 1; a=b=1e-30, op=0 -> 0x00000000, underflow 1.
REQ-031 a=1.0, b=0, op=1 -> 0x7F800000, div_by_zero 1 after 2 cycles; a=0, b=0x7F800000, op=0 -> 0x7FC00000, invalid 1.
REQ-032 out_ready low 5 cycles in DONE -> result/flags stable, in_ready 0, in_valid pulses ignored; rst_n low mid-ITER -> out_valid 0, next op correct.
REQ-033 EXP_W=11, MAN_W=52: 2121121.123123 * 1212121.121212 -> bit-exact truncated double product, out_valid 55 cycles after accept.
